hex_display_scanner: RTL and testbench
======================================

// Module: hex_display_scanner
// PURPOSE
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment hex digits.
//   Latches a packed hex value and scans one digit per PRESCALE clocks.
//   Drives shared active-low segment/dp lines plus one enable per digit.
//   Loaded values are applied only at frame boundaries (no tearing).
//   Optional leading-zero blanking. Successor to the single-digit combinational decoder.
// PARAMETERS
//   NUM_DIGITS    4     digits scanned, >=1; digit 0 = least-significant nibble
//   PRESCALE      1000  clocks each digit is displayed, >=2
//   LZ_BLANK      1     1 = blank leading zero digits; digit 0 always shown
//   EN_ACTIVE_LOW 1     1 = digit_en active-low, 0 = active-high
// PORTS
//   clk        in   1             rising-edge clock
//   reset      in   1             synchronous, active-high
//   load       in   1             capture value/dp_mask this cycle
//   value      in   4*NUM_DIGITS  packed hex nibbles, [3:0] = digit 0
//   dp_mask    in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank      in   1             1 = all digits dark (level, immediate)
//   segments   out  7             {g,f,e,d,c,b,a}, active-low, registered
//   dp_n       out  1             decimal point, active-low, registered
//   digit_en   out  NUM_DIGITS    one-hot digit enable (polarity per EN_ACTIVE_LOW)
//   frame_done out  1             1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//   Reset: prescaler=0, idx=0, active/pending regs=0, pending_v=0;
//     segments=7'h7F, dp_n=1, digit_en all inactive, frame_done=0.
//   Prescaler counts 0..PRESCALE-1; at terminal count it returns to 0 and idx
//     advances; idx NUM_DIGITS-1 -> 0 wraps (frame boundary).
//   frame_done=1 on the cycle after the wrap edge; otherwise 0.
//   Anti-ghost: when prescaler==0, digit_en all inactive and segments=7'h7F;
//     for prescaler 1..PRESCALE-1 digit_en[idx] is active only.
//   load=1: pending <= {value,dp_mask}, pending_v <= 1; a later load before the
//     boundary overwrites pending (last wins).
//   Frame boundary: if load=1 that cycle, active <= inputs directly; else if
//     pending_v, active <= pending. pending_v cleared in both cases.
//   Decode (nibble -> segments): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//     8:00 9:18 A:08 B:03 C:46 D:21 E:06 F:0E (hex, 7-bit).
//   LZ_BLANK=1: digit k>0 is blank (segments=7F) if nibbles k..NUM_DIGITS-1 all
//     zero and dp_mask[k]=0; its enable still follows the scan.
//   dp_n = ~dp_mask[idx] of active set; forced 1 when blanked or anti-ghost.
//   blank=1: digit_en all inactive, segments=7F, dp_n=1 from next cycle; scan,
//     prescaler, loads and frame_done continue unaffected.
//   All outputs registered: they reflect idx/prescaler state with 1-cycle latency.
//   reset mid-scan returns to reset state on next edge; pending load discarded.
// TESTING (NUM_DIGITS=4, PRESCALE=4, EN_ACTIVE_LOW=1 unless noted)
//   After reset, no load -> digit0 shows 40, digits 1-3 blank (LZ), en 1110 in
//     turn; frame_done every 16 cycles.
//   load value=16'h1A3F mid-frame -> old frame completes unchanged; next frame
//     digits 0..3 show 0E,30,08,79.
//   Two loads (16'h0001 then 16'h0F00) in same frame -> only 16'h0F00 displayed;
//     load coincident with wrap -> applied that boundary.
//   LZ_BLANK=0, value 16'h0005 -> shows 12,40,40,40; LZ_BLANK=1, dp_mask=4'b0100
//     -> digit 2 shows 40 with dp_n=0, digit 3 blank.
//   blank pulsed 10 cycles -> all en inactive, segs 7F; frame_done cadence
//     unchanged; display resumes at correct idx.
//   Every digit switch: exactly one cycle with all en inactive; reset mid-frame
//     -> reset values next cycle, pending value never shown.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Multiplexed driver for NUM_DIGITS common-anode 7-segment hex digits.
// Scans one digit per PRESCALE clocks, blanks the first cycle of each digit
// slot to avoid ghosting, and swaps in newly loaded values only at frame
// boundaries so a frame never shows a mix of old and new digits.
module hex_display_scanner #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned PRESCALE      = 1000,
  parameter int unsigned LZ_BLANK      = 1,
  parameter int unsigned EN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF   = (EN_ACTIVE_LOW != 0) ?
                                               {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_OFF  = 7'h7F;

  logic [PS_W-1:0]       prescaler;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      active_val;
  logic [NUM_DIGITS-1:0] active_dp;
  logic [VAL_W-1:0]      pending_val;
  logic [NUM_DIGITS-1:0] pending_dp;
  logic                  pending_v;

  logic                  tick_c;
  logic                  wrap_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_dp_c;
  logic                  cur_lz_c;
  logic                  zero_above_c;
  logic [NUM_DIGITS-1:0] onehot_c;
  logic [6:0]            seg_dec_c;

  // Terminal-count and frame-boundary strobes.
  always_comb begin
    tick_c = (prescaler == PS_LAST);
    wrap_c = tick_c && (idx == IDX_LAST);
  end

  // Prescaler and digit index scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tick_c) begin
      prescaler <= '0;
      idx       <= wrap_c ? '0 : idx + IDX_W'(1);
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  // Pending capture on load; promote to active set only at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_val  <= '0;
      active_dp   <= '0;
      pending_val <= '0;
      pending_dp  <= '0;
      pending_v   <= 1'b0;
    end else begin
      if (load) begin
        pending_val <= value;
        pending_dp  <= dp_mask;
        pending_v   <= 1'b1;
      end
      if (wrap_c) begin
        if (load) begin
          active_val <= value;
          active_dp  <= dp_mask;
        end else if (pending_v) begin
          active_val <= pending_val;
          active_dp  <= pending_dp;
        end
        pending_v <= 1'b0;
      end
    end
  end

  // Select the scanned digit and evaluate leading-zero blanking from the top down.
  always_comb begin
    cur_nib_c    = 4'h0;
    cur_dp_c     = 1'b0;
    cur_lz_c     = 1'b0;
    zero_above_c = 1'b1;
    onehot_c     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above_c = zero_above_c & (active_val[k*4 +: 4] == 4'h0);
      if (idx == IDX_W'(k)) begin
        onehot_c[k] = 1'b1;
        cur_nib_c   = active_val[k*4 +: 4];
        cur_dp_c    = active_dp[k];
        cur_lz_c    = (LZ_BLANK != 0) && (k != 0) && zero_above_c && !active_dp[k];
      end
    end
  end

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    seg_dec_c = SEG_OFF;
    case (cur_nib_c)
      4'h0: seg_dec_c = 7'h40;
      4'h1: seg_dec_c = 7'h79;
      4'h2: seg_dec_c = 7'h24;
      4'h3: seg_dec_c = 7'h30;
      4'h4: seg_dec_c = 7'h19;
      4'h5: seg_dec_c = 7'h12;
      4'h6: seg_dec_c = 7'h02;
      4'h7: seg_dec_c = 7'h78;
      4'h8: seg_dec_c = 7'h00;
      4'h9: seg_dec_c = 7'h18;
      4'hA: seg_dec_c = 7'h08;
      4'hB: seg_dec_c = 7'h03;
      4'hC: seg_dec_c = 7'h46;
      4'hD: seg_dec_c = 7'h21;
      4'hE: seg_dec_c = 7'h06;
      4'hF: seg_dec_c = 7'h0E;
      default: seg_dec_c = SEG_OFF;
    endcase
  end

  // Registered display outputs; slot 0 of each digit and blank force all dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      segments   <= SEG_OFF;
      dp_n       <= 1'b1;
      digit_en   <= EN_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_c;
      if (blank || (prescaler == '0)) begin
        segments <= SEG_OFF;
        dp_n     <= 1'b1;
        digit_en <= EN_OFF;
      end else begin
        segments <= cur_lz_c ? SEG_OFF : seg_dec_c;
        dp_n     <= cur_lz_c | ~cur_dp_c;
        digit_en <= onehot_c ^ EN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: a cycle-count based model predicts
// every output per cycle for both LZ_BLANK settings.
module tb_hex_display_scanner;

  localparam int unsigned N = 4;
  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        reset, load, blank;
  logic [15:0] value;
  logic [3:0]  dp_mask;

  logic [6:0]  seg_a, seg_b;
  logic        dpn_a, dpn_b;
  logic [3:0]  en_a, en_b;
  logic        fd_a, fd_b;

  hex_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .LZ_BLANK(1), .EN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
    .blank(blank), .segments(seg_a), .dp_n(dpn_a), .digit_en(en_a), .frame_done(fd_a));

  hex_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .LZ_BLANK(0), .EN_ACTIVE_LOW(1)) dut_nlz (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
    .blank(blank), .segments(seg_b), .dp_n(dpn_b), .digit_en(en_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dpn;
    logic [3:0] en;
    logic       fd;
    logic [6:0] seg_nlz;
    logic       dpn_nlz;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          m_cnt;
  logic [15:0] m_av, m_pv;
  logic [3:0]  m_ad, m_pd;
  bit          m_pvld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pred(input bit lz, input int i);
    logic [15:0] sh;
    bit          blk;
    sh  = m_av >> (4 * i);
    blk = lz && (i > 0) && (sh == 16'h0) && !m_ad[i];
    return blk ? {7'h7F, 1'b1} : {dec[sh[3:0]], ~m_ad[i]};
  endfunction

  task automatic cyc(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] d, input bit bl);
    exp_t e, g;
    int   p, i;
    bit   wrap;
    reset = r; load = ld; value = v; dp_mask = d; blank = bl;
    if (r) begin
      e = '{seg: 7'h7F, dpn: 1'b1, en: 4'hF, fd: 1'b0, seg_nlz: 7'h7F, dpn_nlz: 1'b1};
      m_cnt = 0; m_av = '0; m_ad = '0; m_pv = '0; m_pd = '0; m_pvld = 0;
    end else begin
      p    = m_cnt % P;
      i    = m_cnt / P;
      wrap = (m_cnt == N * P - 1);
      e.fd = wrap;
      if (bl || p == 0) begin
        e.seg = 7'h7F; e.dpn = 1'b1; e.en = 4'hF; e.seg_nlz = 7'h7F; e.dpn_nlz = 1'b1;
      end else begin
        e.en = ~(4'(1) << i);
        {e.seg, e.dpn}         = pred(1'b1, i);
        {e.seg_nlz, e.dpn_nlz} = pred(1'b0, i);
      end
      if (wrap) begin
        if (ld) begin m_av = v; m_ad = d; end
        else if (m_pvld) begin m_av = m_pv; m_ad = m_pd; end
        m_pvld = 0;
        m_cnt  = 0;
      end else begin
        if (ld) begin m_pv = v; m_pd = d; m_pvld = 1; end
        m_cnt++;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    if (fd_a) fd_cnt++;
    check("segments", 32'(seg_a), 32'(g.seg));
    check("dp_n", 32'(dpn_a), 32'(g.dpn));
    check("digit_en", 32'(en_a), 32'(g.en));
    check("frame_done", 32'(fd_a), 32'(g.fd));
    check("segments_nlz", 32'(seg_b), 32'(g.seg_nlz));
    check("dp_n_nlz", 32'(dpn_b), 32'(g.dpn_nlz));
    check("digit_en_nlz", 32'(en_b), 32'(g.en));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, value, dp_mask, 1'b0);
  endtask

  task automatic idle_until(input int t);
    for (int k = 0; k < 2 * N * P && m_cnt != t; k++) cyc(1'b0, 1'b0, value, dp_mask, 1'b0);
    check("align", 32'(m_cnt), 32'(t));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dp_mask = '0;
    m_cnt = 0; m_av = '0; m_ad = '0; m_pv = '0; m_pd = '0; m_pvld = 0;

    repeat (3) cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    // Idle after reset: digit 0 shows 0, others blank; four frames in 64 cycles.
    fd_cnt = 0;
    idle(64);
    check("fd_cadence_idle", 32'(fd_cnt), 32'd4);

    // Mid-frame load appears only from the next frame.
    idle_until(5);
    cyc(1'b0, 1'b1, 16'h1A3F, 4'h0, 1'b0);
    idle(40);

    // Two loads in one frame: last wins.
    idle_until(3);
    cyc(1'b0, 1'b1, 16'h0001, 4'h0, 1'b0);
    idle_until(9);
    cyc(1'b0, 1'b1, 16'h0F00, 4'h0, 1'b0);
    idle(20);

    // Load coincident with the wrap is applied at that boundary.
    idle_until(15);
    cyc(1'b0, 1'b1, 16'h2B07, 4'h1, 1'b0);
    idle(20);

    // Leading zeros: 0005, then 0000 with dp on digit 2.
    idle_until(2);
    cyc(1'b0, 1'b1, 16'h0005, 4'h0, 1'b0);
    idle(36);
    idle_until(2);
    cyc(1'b0, 1'b1, 16'h0000, 4'b0100, 1'b0);
    idle(36);

    // Blank for 10 cycles; frame cadence unaffected.
    fd_cnt = 0;
    idle(6);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, value, dp_mask, 1'b1);
    idle(48);
    check("fd_cadence_blank", 32'(fd_cnt), 32'd4);

    // Reset mid-frame discards a pending load.
    idle_until(4);
    cyc(1'b0, 1'b1, 16'hBEEF, 4'hF, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, value, dp_mask, 1'b0);
    idle(40);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 128) == 0, ($urandom % 8) == 0, 16'($urandom), 4'($urandom),
          ($urandom % 16) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
